gate_commutation_sequencer: RTL and testbench

- Downstream stage of the MPC switching-state decoder.
- Consumes the registered 18-bit gate pattern and drives the power-stage gate lines.
- Guarantees safe transitions between patterns:
  - outgoing switches turn off immediately;
  - incoming switches turn on only after a programmable dead time;
  - each applied pattern is held for a minimum time.
- Also provides a latched, fail-safe fault shutdown.

---
 rtl/mpc_gate_pkg.sv | 14 +
 rtl/gate_timer.sv | 31 +++
 rtl/gate_commutation_sequencer.sv | 143 ++++++++++++++
 tb/tb_gate_commutation_sequencer.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/mpc_gate_pkg.sv
// Shared definitions for the MPC gate path: pattern width, default timing
// and the commutation sequencer state encoding.
package mpc_gate_pkg;

  localparam int GATE_W          = 18;
  localparam int DEAD_CYCLES_DEF = 50;
  localparam int HOLD_CYCLES_DEF = 100;

  localparam logic [1:0] ST_STEADY = 2'd0;
  localparam logic [1:0] ST_DEAD   = 2'd1;
  localparam logic [1:0] ST_HOLD   = 2'd2;
  localparam logic [1:0] ST_FAULT  = 2'd3;

endpackage

// File: rtl/gate_timer.sv
// Loadable down-counter with a zero flag; one instance times both the
// dead-time and the hold phase of the commutation sequencer.
module gate_timer #(
  parameter int CNT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_clr,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_dec,
  output logic             o_zero
);

  logic [CNT_W-1:0] r_cnt;

  // Decrement saturates at zero so an idle phase can never wrap around.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)
      r_cnt <= '0;
    else if (i_clr)
      r_cnt <= '0;
    else if (i_load)
      r_cnt <= i_load_val;
    else if (i_dec && (r_cnt != '0))
      r_cnt <= r_cnt - 1'b1;
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/gate_commutation_sequencer.sv
// Sequences gate-pattern changes: outgoing switches off at once, incoming
// switches on after a dead time, then a minimum hold; latched fault shutdown.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_STEADY | gate == applied, watching pat_in for a change
// ST_DEAD   | outgoing bits off, waiting out the dead time before turn-on
// ST_HOLD   | new pattern applied, pat_in ignored until hold expires
// ST_FAULT  | all gates off, waiting for fault_clr with fault low
module gate_commutation_sequencer
  import mpc_gate_pkg::*;
#(
  parameter int WIDTH       = GATE_W,
  parameter int DEAD_CYCLES = DEAD_CYCLES_DEF,
  parameter int HOLD_CYCLES = HOLD_CYCLES_DEF,
  parameter int CNT_W       = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_pat_in,
  input  logic             i_fault,
  input  logic             i_fault_clr,
  output logic [WIDTH-1:0] o_gate,
  output logic             o_busy,
  output logic             o_applied_stb,
  output logic             o_fault_active
);

  localparam int HOLD_LD_I = (HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0;
  localparam logic [CNT_W-1:0] DEAD_LD = CNT_W'(DEAD_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LD = CNT_W'(HOLD_LD_I);

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_gate;
  logic [WIDTH-1:0] r_applied;
  logic [WIDTH-1:0] r_target;
  logic             r_stb;

  logic [1:0]       w_state_nxt;
  logic [WIDTH-1:0] w_gate_nxt;
  logic [WIDTH-1:0] w_applied_nxt;
  logic [WIDTH-1:0] w_target_nxt;
  logic             w_stb_nxt;
  logic             w_tmr_clr;
  logic             w_tmr_load;
  logic [CNT_W-1:0] w_tmr_val;
  logic             w_tmr_dec;
  logic             w_tmr_zero;

  gate_timer #(.CNT_W(CNT_W)) u_timer (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_clr      (w_tmr_clr),
    .i_load     (w_tmr_load),
    .i_load_val (w_tmr_val),
    .i_dec      (w_tmr_dec),
    .o_zero     (w_tmr_zero)
  );

  always_comb begin
    w_state_nxt   = r_state;
    w_gate_nxt    = r_gate;
    w_applied_nxt = r_applied;
    w_target_nxt  = r_target;
    w_stb_nxt     = 1'b0;
    w_tmr_clr     = 1'b0;
    w_tmr_load    = 1'b0;
    w_tmr_val     = DEAD_LD;
    w_tmr_dec     = 1'b0;
    if (i_fault) begin
      w_state_nxt   = ST_FAULT;
      w_gate_nxt    = '0;
      w_applied_nxt = '0;
      w_tmr_clr     = 1'b1;
    end else begin
      case (r_state)
        ST_STEADY: begin
          if (i_pat_in != r_applied) begin
            w_target_nxt = i_pat_in;
            w_gate_nxt   = r_applied & i_pat_in;
            w_tmr_load   = 1'b1;
            w_state_nxt  = ST_DEAD;
          end
        end
        ST_DEAD: begin
          // A re-request may only remove bits; the dead time starts over.
          if (i_pat_in != r_target) begin
            w_target_nxt = i_pat_in;
            w_gate_nxt   = r_gate & i_pat_in;
            w_tmr_load   = 1'b1;
          end else if (w_tmr_zero) begin
            w_gate_nxt    = r_target;
            w_applied_nxt = r_target;
            w_stb_nxt     = 1'b1;
            if (HOLD_CYCLES > 0) begin
              w_tmr_load  = 1'b1;
              w_tmr_val   = HOLD_LD;
              w_state_nxt = ST_HOLD;
            end else begin
              w_state_nxt = ST_STEADY;
            end
          end else begin
            w_tmr_dec = 1'b1;
          end
        end
        ST_HOLD: begin
          if (w_tmr_zero)
            w_state_nxt = ST_STEADY;
          else
            w_tmr_dec = 1'b1;
        end
        default: begin
          if (i_fault_clr) begin
            w_state_nxt   = ST_STEADY;
            w_applied_nxt = '0;
          end
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= ST_STEADY;
      r_gate    <= '0;
      r_applied <= '0;
      r_target  <= '0;
      r_stb     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_gate    <= w_gate_nxt;
      r_applied <= w_applied_nxt;
      r_target  <= w_target_nxt;
      r_stb     <= w_stb_nxt;
    end
  end

  assign o_gate         = r_gate;
  assign o_busy         = (r_state == ST_DEAD) || (r_state == ST_HOLD);
  assign o_applied_stb  = r_stb;
  assign o_fault_active = (r_state == ST_FAULT);

endmodule

// File: tb/tb_gate_commutation_sequencer.sv
// Bench for gate_commutation_sequencer: directed scenarios plus random traffic,
// checked every cycle against a deadline-based reference model.
module tb_gate_commutation_sequencer;
  import mpc_gate_pkg::*;

  localparam int W    = GATE_W;
  localparam int DEAD = 4;
  localparam int HOLD = 6;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] pat = '0;
  logic         flt = 1'b0;
  logic         clr = 1'b0;
  logic [W-1:0] gate;
  logic         busy;
  logic         stb;
  logic         fact;

  always #5 clk = ~clk;

  gate_commutation_sequencer #(
    .WIDTH(W), .DEAD_CYCLES(DEAD), .HOLD_CYCLES(HOLD), .CNT_W(16)
  ) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_pat_in       (pat),
    .i_fault        (flt),
    .i_fault_clr    (clr),
    .o_gate         (gate),
    .o_busy         (busy),
    .o_applied_stb  (stb),
    .o_fault_active (fact)
  );

  int checks = 0;
  int failures = 0;

  // Model: a transition is a pair of deadlines (apply edge, first edge that
  // may sample a new change) rather than a state machine with a counter.
  int           n = 0;
  int           apply_at = -1;
  int           free_at = 0;
  logic [W-1:0] m_gate = '0;
  logic [W-1:0] m_applied = '0;
  logic [W-1:0] m_target = '0;
  logic         m_fault = 1'b0;
  logic         m_stb = 1'b0;
  int           stb_cnt;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_gate = '0; m_applied = '0; m_target = '0; m_fault = 1'b0; m_stb = 1'b0;
    apply_at = -1; free_at = n;
  endtask

  task automatic model_edge(input logic [W-1:0] p, input logic f, input logic c);
    m_stb = 1'b0;
    if (f) begin
      m_gate = '0; m_applied = '0; m_fault = 1'b1; apply_at = -1;
    end else if (m_fault) begin
      if (c) begin m_fault = 1'b0; free_at = n + 1; end
    end else if (apply_at >= 0) begin
      if (p != m_target) begin
        m_target = p; m_gate = m_gate & p; apply_at = n + DEAD;
      end else if (n == apply_at) begin
        m_gate = m_target; m_applied = m_target; m_stb = 1'b1;
        apply_at = -1; free_at = n + HOLD + 1;
      end
    end else if (n >= free_at && p != m_applied) begin
      m_target = p; m_gate = m_applied & p; apply_at = n + DEAD;
    end
  endtask

  task automatic step(input logic [W-1:0] p, input logic f, input logic c);
    logic [W-1:0] prev;
    logic         exp_busy;
    pat = p; flt = f; clr = c;
    prev = gate;
    @(posedge clk);
    n++;
    model_edge(p, f, c);
    #1;
    exp_busy = (apply_at >= 0) || (!m_fault && (n + 1 < free_at));
    check_val("gate", 32'(gate), 32'(m_gate));
    check_val("busy", 32'(busy), 32'(exp_busy));
    check_val("applied_stb", 32'(stb), 32'(m_stb));
    check_val("fault_active", 32'(fact), 32'(m_fault));
    if (!m_stb)
      check_val("no_rise", 32'(gate & ~prev), 32'd0);
  endtask

  initial begin
    logic [W-1:0] cur;
    logic         f;
    logic         c;

    #12;
    check_val("rst_gate", 32'(gate), 32'd0);
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_stb", 32'(stb), 32'd0);
    check_val("rst_fact", 32'(fact), 32'd0);
    rst_n = 1'b1;
    model_reset();

    // 1: first pattern after reset
    stb_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      step(18'h0C303, 1'b0, 1'b0);
      stb_cnt += int'(stb);
      if (i < 4) check_val("t1_gate_off", 32'(gate), 32'd0);
    end
    check_val("t1_stb_cnt", 32'(stb_cnt), 32'd1);
    check_val("t1_gate", 32'(gate), 32'h0C303);
    repeat (7) step(18'h0C303, 1'b0, 1'b0);

    // 2: disjoint pattern change
    step(18'h030CC, 1'b0, 1'b0);
    check_val("t2_off", 32'(gate), 32'h00000);
    repeat (4) step(18'h030CC, 1'b0, 1'b0);
    check_val("t2_gate", 32'(gate), 32'h030CC);
    repeat (7) step(18'h030CC, 1'b0, 1'b0);

    // 3: re-request in the middle of the dead time
    step(18'h0C303, 1'b0, 1'b0);
    step(18'h0C303, 1'b0, 1'b0);
    step(18'h0C30C, 1'b0, 1'b0);
    repeat (3) step(18'h0C30C, 1'b0, 1'b0);
    check_val("t3_still_off", 32'(gate), 32'd0);
    step(18'h0C30C, 1'b0, 1'b0);
    check_val("t3_gate", 32'(gate), 32'h0C30C);

    // 4: change requested during hold
    step(18'h0C30C, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step(18'h0030F, 1'b0, 1'b0);
      check_val("t4_frozen", 32'(gate), 32'h0C30C);
    end
    step(18'h0030F, 1'b0, 1'b0);
    check_val("t4_start", 32'(gate), 32'h0030C);
    check_val("t4_busy", 32'(busy), 32'd1);

    // 5: fault while in dead time
    step(18'h0030F, 1'b0, 1'b0);
    step(18'h0030F, 1'b1, 1'b0);
    check_val("t5_gate", 32'(gate), 32'd0);
    check_val("t5_fact", 32'(fact), 32'd1);
    step(18'h0030F, 1'b1, 1'b1);
    check_val("t5_clr_blocked", 32'(fact), 32'd1);
    step(18'h0030F, 1'b0, 1'b1);
    check_val("t5_released", 32'(fact), 32'd0);
    repeat (4) step(18'h0030F, 1'b0, 1'b0);
    check_val("t5_dead", 32'(gate), 32'd0);
    step(18'h0030F, 1'b0, 1'b0);
    check_val("t5_reapply", 32'(gate), 32'h0030F);

    // 6: async reset in the middle of hold
    repeat (2) step(18'h0030F, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check_val("t6_async_gate", 32'(gate), 32'd0);
    check_val("t6_async_busy", 32'(busy), 32'd0);
    model_reset();
    #3 rst_n = 1'b1;
    stb_cnt = 0;
    for (int i = 0; i < 15; i++) begin
      step('0, 1'b0, 1'b0);
      stb_cnt += int'(stb);
    end
    check_val("t6_stb_cnt", 32'(stb_cnt), 32'd0);

    // random traffic
    cur = '0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 5) == 0) begin
        case ($urandom_range(0, 3))
          0: cur = '0;
          1: cur = cur ^ (W'(1) << $urandom_range(0, W - 1));
          default: cur = W'($urandom);
        endcase
      end
      f = ($urandom_range(0, 99) < 2);
      c = ($urandom_range(0, 7) == 0);
      step(cur, f, c);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
